rv32i_core_sequencer: RTL and testbench
=======================================

# rv32i_core_sequencer

Multi-cycle control sequencer for the RV32I core. Steps each instruction through fetch, decode, execute, memory and writeback. Drives the strobes that load the instruction register, share the single memory port between instruction fetch and data access, commit the PC, and enable the register write. It consumes the per-instruction control flags produced by the RV32I decoder, plus the branch-condition result, and raises a sticky trap on an illegal opcode or a memory timeout.

## Interface
Parameters:
- dataW, 32, datapath width; sets the `instCount` width.
- memTimeout, 64, max cycles a memory request may wait for `memReady`; 0 disables the timeout.

Ports:
- clock  in  1  system clock; all state updates on rising edge.
- nReset  in  1  asynchronous active-low reset.
- run  in  1  allow instruction issue; sampled in IDLE and on WB exit only.
- opcode  in  7  `IR[6:0]` of the held instruction.
- regWriteControl, ramRead, ramWrite, testBranch, alwaysBranch  in  1 each  decoder flags for the held instruction.
- branchTaken  in  1  branch-condition result; valid in WB.
- memReady  in  1  shared memory port completion, single-cycle pulse or level.
- memReq  out  1  memory port request.
- memWe  out  1  write strobe, qualified by `memReq`.
- memSelIns  out  1  address mux: 1 = PC (fetch), 0 = ALU result (data).
- irLoad  out  1  latch memory read data into IR.
- pcWrite  out  1  commit the next PC.
- pcBranch  out  1  next PC = branch target (1) or PC+4 (0); valid with `pcWrite`.
- regWriteEn  out  1  register-file write enable.
- wbFromRam  out  1  writeback source = memory read data.
- trap  out  1  sticky fault flag.
- trapCause  out  2  1 = illegal opcode, 2 = fetch timeout, 3 = data timeout.
- instCount  out  dataW  retired-instruction counter.

## Operation
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, TRAP.
- **IDLE**
  - All strobes 0.
  - `run`=1 -> FETCH; otherwise stay.
- **FETCH**
  - `memReq`=1, `memSelIns`=1, `memWe`=0.
  - `memReady`=1 -> `irLoad`=1 this cycle, then -> DECODE.
- **DECODE** (one cycle)
  - Legal opcodes: 0110011, 0010011, 0110111, 0010111, 1101111, 1100111, 1100011, 0000011, 0100011.
  - Legal -> EXEC.
  - Any other opcode (including FENCE and SYSTEM) -> TRAP, cause 1.
- **EXEC** (one cycle, ALU settles)
  - `ramRead`|`ramWrite` -> MEM; otherwise -> WB.
- **MEM**
  - `memReq`=1, `memSelIns`=0, `memWe`=`ramWrite`.
  - `memReady`=1 -> WB.
- **WB** (one cycle)
  - `pcWrite`=1, `pcBranch`=`alwaysBranch` | (`testBranch` & `branchTaken`).
  - `regWriteEn`=`regWriteControl`, `wbFromRam`=`ramRead` & ~`ramWrite`.
  - `instCount`+1, wrapping 2^dataW-1 -> 0.
  - Exit: -> FETCH if `run`, else IDLE.
- **TRAP**
  - All strobes 0; `trap`=1; `trapCause` held.
  - Exit only by reset.
  - PC is not committed for the faulting instruction; `instCount` does not increment.
- **Timeout**
  - A wait counter of width clog2(memTimeout+1) clears on entry to FETCH or MEM and increments each cycle in that state with `memReady`=0.
  - With count = memTimeout-1 and `memReady`=0 -> TRAP (cause 2 from FETCH, 3 from MEM), i.e. after exactly memTimeout unanswered request cycles.
  - `memReady`=1 in that same cycle wins: normal transition, no trap.
- `run` dropping mid-instruction has no effect until WB completes.
- `memReady` outside FETCH/MEM is ignored.

## Timing
- Reset (async assert, sync-clean deassert):
  - state = IDLE, `instCount`=0, `trap`=0, `trapCause`=0, wait counter = 0.
  - All combinational strobes are therefore 0.
- `trap`, `trapCause`, `instCount` are registered.
- All other outputs are combinational from state plus the listed inputs (Mealy on `memReady` for `irLoad`, on flags for the WB and MEM strobes).
- Zero-wait memory latency:
  - ALU, LUI, AUIPC, JAL, JALR, branch: 4 cycles (FETCH, DECODE, EXEC, WB).
  - Load/store: 5 cycles.
  - Each memory wait cycle adds 1.
- Back-to-back issue: WB -> FETCH with no bubble while `run`=1.
- `nReset` asserted in any state -> IDLE immediately, with no `pcWrite`/`regWriteEn` glitch after the assert edge.

## Test plan
- ALU stream:
  - Stimulus: `run`=1, `memReady` tied 1, opcode 0010011 with `regWriteControl`=1.
  - Required: `pcWrite` and `regWriteEn` pulse every 4th cycle; `instCount`=3 after 12 cycles; `memReq` high only in FETCH cycles.
- Load with wait states:
  - Stimulus: opcode 0000011, `ramRead`=1, `memReady` delayed 3 cycles in MEM.
  - Required: `memSelIns`=0 and `memWe`=0 for 4 MEM cycles; WB has `wbFromRam`=1 and `regWriteEn`=1; total 8 cycles.
- Branch:
  - Stimulus: opcode 1100011, `testBranch`=1, `branchTaken` = 1 then 0 on two instructions.
  - Required: `pcBranch` = 1 then 0; `regWriteEn`=0 both times.
- Illegal opcode:
  - Stimulus: opcode 1110011.
  - Required: TRAP at DECODE+1; `trap`=1, `trapCause`=1; `instCount` unchanged; no further `memReq` until reset.
- Timeout boundary, memTimeout=4:
  - Stimulus A: `memReady` first asserted on FETCH cycle 4 -> normal DECODE.
  - Stimulus B: `memReady` never asserted -> `trap`=1, `trapCause`=2 after exactly 4 request cycles.
  - Stimulus C: the same in MEM -> `trapCause`=3.
- Reset mid-MEM and `run` gating:
  - Stimulus: assert `nReset`=0 during MEM; then release with `run`=0.
  - Required: outputs 0 and `instCount`=0 immediately after assert; after release, stays in IDLE with `memReq`=0; `run`=1 -> FETCH next cycle.

Source files
------------

// File: rtl/rv32i_core_sequencer.sv
// Multi-cycle control sequencer for the RV32I core: walks each instruction through
// fetch/decode/execute/memory/writeback and raises a sticky trap on faults.
module rv32i_core_sequencer #(
    parameter int unsigned dataW      = 32,
    parameter int unsigned memTimeout = 64
) (
    input  logic             clock,
    input  logic             nReset,
    input  logic             run,
    input  logic [6:0]       opcode,
    input  logic             regWriteControl,
    input  logic             ramRead,
    input  logic             ramWrite,
    input  logic             testBranch,
    input  logic             alwaysBranch,
    input  logic             branchTaken,
    input  logic             memReady,
    output logic             memReq,
    output logic             memWe,
    output logic             memSelIns,
    output logic             irLoad,
    output logic             pcWrite,
    output logic             pcBranch,
    output logic             regWriteEn,
    output logic             wbFromRam,
    output logic             trap,
    output logic [1:0]       trapCause,
    output logic [dataW-1:0] instCount
);

    localparam int unsigned WAIT_W = (memTimeout > 0) ? $clog2(memTimeout + 1) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((memTimeout > 0) ? memTimeout - 1 : 0);
    localparam logic TIMEOUT_ON = (memTimeout > 0);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        MEM    = 3'd4,
        WB     = 3'd5,
        TRAP   = 3'd6
    } state_t;

    state_t             state_q, state_d;
    logic [WAIT_W-1:0]  wait_q, wait_d;
    logic               trap_q, trap_d;
    logic [1:0]         trap_cause_q, trap_cause_d;
    logic [dataW-1:0]   inst_count_q, inst_count_d;
    logic               opcode_legal;
    logic               timeout_hit;

    // Opcodes the core implements; FENCE and SYSTEM deliberately fall through as illegal.
    always_comb begin
        opcode_legal = 1'b0;
        case (opcode)
            7'b0110011, 7'b0010011, 7'b0110111, 7'b0010111, 7'b1101111,
            7'b1100111, 7'b1100011, 7'b0000011, 7'b0100011: opcode_legal = 1'b1;
            default: opcode_legal = 1'b0;
        endcase
    end

    assign timeout_hit = TIMEOUT_ON && (wait_q == WAIT_LAST);

    always_comb begin
        state_d      = state_q;
        wait_d       = wait_q;
        trap_d       = trap_q;
        trap_cause_d = trap_cause_q;
        inst_count_d = inst_count_q;
        memReq       = 1'b0;
        memWe        = 1'b0;
        memSelIns    = 1'b0;
        irLoad       = 1'b0;
        pcWrite      = 1'b0;
        pcBranch     = 1'b0;
        regWriteEn   = 1'b0;
        wbFromRam    = 1'b0;

        case (state_q)
            IDLE: begin
                if (run) begin
                    state_d = FETCH;
                    wait_d  = '0;
                end
            end
            FETCH: begin
                memReq    = 1'b1;
                memSelIns = 1'b1;
                // A response in the final allowed cycle still beats the timeout.
                if (memReady) begin
                    irLoad  = 1'b1;
                    state_d = DECODE;
                end else if (timeout_hit) begin
                    state_d      = TRAP;
                    trap_d       = 1'b1;
                    trap_cause_d = 2'd2;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            DECODE: begin
                if (opcode_legal) begin
                    state_d = EXEC;
                end else begin
                    state_d      = TRAP;
                    trap_d       = 1'b1;
                    trap_cause_d = 2'd1;
                end
            end
            EXEC: begin
                if (ramRead | ramWrite) begin
                    state_d = MEM;
                    wait_d  = '0;
                end else begin
                    state_d = WB;
                end
            end
            MEM: begin
                memReq = 1'b1;
                memWe  = ramWrite;
                if (memReady) begin
                    state_d = WB;
                end else if (timeout_hit) begin
                    state_d      = TRAP;
                    trap_d       = 1'b1;
                    trap_cause_d = 2'd3;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            WB: begin
                pcWrite      = 1'b1;
                pcBranch     = alwaysBranch | (testBranch & branchTaken);
                regWriteEn   = regWriteControl;
                wbFromRam    = ramRead & ~ramWrite;
                inst_count_d = inst_count_q + dataW'(1);
                wait_d       = '0;
                state_d      = run ? FETCH : IDLE;
            end
            TRAP: begin
                state_d = TRAP;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge nReset) begin
        if (!nReset) begin
            state_q      <= IDLE;
            wait_q       <= '0;
            trap_q       <= 1'b0;
            trap_cause_q <= 2'd0;
            inst_count_q <= '0;
        end else begin
            state_q      <= state_d;
            wait_q       <= wait_d;
            trap_q       <= trap_d;
            trap_cause_q <= trap_cause_d;
            inst_count_q <= inst_count_d;
        end
    end

    assign trap      = trap_q;
    assign trapCause = trap_cause_q;
    assign instCount = inst_count_q;

endmodule

// File: tb/tb_rv32i_core_sequencer.sv
// Bench for rv32i_core_sequencer: directed scenarios plus a random instruction stream
// checked cycle by cycle against an instruction-timeline reference model.
module tb_rv32i_core_sequencer;

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned TIMEOUT = 4;

    logic              clock = 1'b0;
    logic              nReset;
    logic              run;
    logic [6:0]        opcode;
    logic              regWriteControl, ramRead, ramWrite, testBranch, alwaysBranch;
    logic              branchTaken, memReady;
    logic              memReq, memWe, memSelIns, irLoad, pcWrite, pcBranch, regWriteEn, wbFromRam;
    logic              trap;
    logic [1:0]        trapCause;
    logic [DATA_W-1:0] instCount;

    int compared    = 0;
    int mismatched  = 0;
    int model_count = 0;
    int cycles;

    logic [8:0] obs_s;
    logic [6:0] legal_ops [9] = '{7'b0110011, 7'b0010011, 7'b0110111, 7'b0010111, 7'b1101111,
                                  7'b1100111, 7'b1100011, 7'b0000011, 7'b0100011};

    localparam logic [8:0] ZERO_V = 9'h000;
    localparam logic [8:0] TRAP_V = 9'h100;

    rv32i_core_sequencer #(.dataW(DATA_W), .memTimeout(TIMEOUT)) dut (
        .clock(clock), .nReset(nReset), .run(run), .opcode(opcode),
        .regWriteControl(regWriteControl), .ramRead(ramRead), .ramWrite(ramWrite),
        .testBranch(testBranch), .alwaysBranch(alwaysBranch), .branchTaken(branchTaken),
        .memReady(memReady), .memReq(memReq), .memWe(memWe), .memSelIns(memSelIns),
        .irLoad(irLoad), .pcWrite(pcWrite), .pcBranch(pcBranch), .regWriteEn(regWriteEn),
        .wbFromRam(wbFromRam), .trap(trap), .trapCause(trapCause), .instCount(instCount)
    );

    always #5 clock = ~clock;

    assign obs_s = {trap, memReq, memWe, memSelIns, irLoad, pcWrite, pcBranch, regWriteEn, wbFromRam};

    function automatic logic [8:0] sv(input logic req, we, sel, ir, pcw, pcb, rwe, wbr);
        return {1'b0, req, we, sel, ir, pcw, pcb, rwe, wbr};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive memReady at the falling edge, check strobes mid-cycle.
    task automatic cyc(input logic rdy, input logic [8:0] exp, input string tag);
        memReady = rdy;
        #1;
        check(tag, 32'(obs_s), 32'(exp));
        @(negedge clock);
    endtask

    task automatic go_fetch();
        run = 1'b1;
        cyc(1'($urandom), ZERO_V, "idle_issue");
    endtask

    task automatic do_reset();
        nReset = 1'b0;
        #1;
        check("rst_strobes", 32'(obs_s), 32'(ZERO_V));
        check("rst_count", instCount, 32'd0);
        check("rst_cause", 32'(trapCause), 32'd0);
        @(negedge clock);
        run         = 1'b0;
        nReset      = 1'b1;
        model_count = 0;
        @(negedge clock);
    endtask

    // Reference timeline: (fw+1) fetch, decode, exec, (mw+1) mem if data access, wb.
    task automatic do_instr(input logic [6:0] op, input logic rw, rr, ww, tb, ab, bt,
                            input int fw, input int mw, input logic run_after, output int n);
        opcode = op; regWriteControl = rw; ramRead = rr; ramWrite = ww;
        testBranch = tb; alwaysBranch = ab; branchTaken = 1'($urandom);
        n = 0;
        for (int i = 0; i <= fw; i++) begin
            cyc(1'(i == fw), sv(1'b1, 1'b0, 1'b1, 1'(i == fw), 1'b0, 1'b0, 1'b0, 1'b0), "fetch");
            n++;
        end
        cyc(1'($urandom), ZERO_V, "decode"); n++;
        cyc(1'($urandom), ZERO_V, "exec");   n++;
        if (rr || ww) begin
            for (int i = 0; i <= mw; i++) begin
                cyc(1'(i == mw), sv(1'b1, ww, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), "mem");
                n++;
            end
        end
        branchTaken = bt;
        run         = run_after;
        cyc(1'($urandom), sv(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, ab | (tb & bt), rw, rr & ~ww), "wb");
        n++;
        model_count++;
        check("inst_count", instCount, 32'(model_count));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        nReset = 1'b1; run = 1'b0; opcode = 7'd0; regWriteControl = 1'b0; ramRead = 1'b0;
        ramWrite = 1'b0; testBranch = 1'b0; alwaysBranch = 1'b0; branchTaken = 1'b0; memReady = 1'b0;
        #1 nReset = 1'b0;
        @(negedge clock);
        @(negedge clock);
        check("reset_strobes", 32'(obs_s), 32'(ZERO_V));
        check("reset_count", instCount, 32'd0);
        check("reset_cause", 32'(trapCause), 32'd0);
        nReset = 1'b1;
        cyc(1'b1, ZERO_V, "idle_hold");

        // ALU stream, zero-wait memory
        go_fetch();
        for (int k = 0; k < 3; k++) begin
            do_instr(7'b0010011, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b1, cycles);
            check("alu_cycles", 32'(cycles), 32'd4);
        end
        check("alu_count3", instCount, 32'd3);

        // Load with three MEM wait states
        do_instr(7'b0000011, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 3, 1'b1, cycles);
        check("load_cycles", 32'(cycles), 32'd8);

        // Conditional branch taken then not taken
        do_instr(7'b1100011, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 0, 0, 1'b1, cycles);
        do_instr(7'b1100011, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 1'b1, cycles);

        // Random stream of legal instructions with wait states below the timeout
        for (int k = 0; k < 24; k++) begin
            logic [6:0] op;
            logic rw, rr, ww, tb, ab;
            op = legal_ops[$urandom_range(0, 8)];
            rw = 1'b1; rr = 1'b0; ww = 1'b0; tb = 1'b0; ab = 1'b0;
            case (op)
                7'b0000011: rr = 1'b1;
                7'b0100011: begin ww = 1'b1; rw = 1'b0; end
                7'b1100011: begin tb = 1'b1; rw = 1'b0; end
                7'b1101111, 7'b1100111: ab = 1'b1;
                default: rw = 1'b1;
            endcase
            do_instr(op, rw, rr, ww, tb, ab, 1'($urandom), $urandom_range(0, 3),
                     $urandom_range(0, 3), 1'(k != 23), cycles);
        end
        cyc(1'b1, ZERO_V, "idle_after_stop");

        // Timeout A: answer on the last allowed fetch cycle
        go_fetch();
        do_instr(7'b0110111, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, TIMEOUT - 1, 0, 1'b0, cycles);
        check("fetch_edge_cycles", 32'(cycles), 32'(TIMEOUT + 3));
        cyc(1'b0, ZERO_V, "idle_after_edge");

        // Timeout B: fetch never answered
        go_fetch();
        for (int i = 0; i < int'(TIMEOUT); i++)
            cyc(1'b0, sv(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), "fetch_wait");
        for (int i = 0; i < 3; i++)
            cyc(1'($urandom), TRAP_V, "trap_fetch");
        check("cause_fetch", 32'(trapCause), 32'd2);
        check("count_fetch_trap", instCount, 32'(model_count));
        do_reset();

        // Timeout C: store whose data access is never answered
        go_fetch();
        opcode = 7'b0100011; regWriteControl = 1'b0; ramRead = 1'b0; ramWrite = 1'b1;
        testBranch = 1'b0; alwaysBranch = 1'b0;
        cyc(1'b1, sv(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0), "fetch");
        cyc(1'b0, ZERO_V, "decode");
        cyc(1'b0, ZERO_V, "exec");
        for (int i = 0; i < int'(TIMEOUT); i++)
            cyc(1'b0, sv(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), "mem_wait");
        cyc(1'b1, TRAP_V, "trap_mem");
        check("cause_mem", 32'(trapCause), 32'd3);
        do_reset();

        // Illegal opcode (SYSTEM) after one retired instruction
        go_fetch();
        do_instr(7'b0110011, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1, 0, 1'b1, cycles);
        opcode = 7'b1110011;
        cyc(1'b1, sv(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0), "fetch_ill");
        cyc(1'b1, ZERO_V, "decode_ill");
        for (int i = 0; i < 4; i++)
            cyc(1'($urandom), TRAP_V, "trap_ill");
        check("cause_ill", 32'(trapCause), 32'd1);
        check("count_ill", instCount, 32'(model_count));
        do_reset();

        // Reset during MEM, then run gating after release
        go_fetch();
        do_instr(7'b0010011, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b1, cycles);
        opcode = 7'b0000011; regWriteControl = 1'b1; ramRead = 1'b1; ramWrite = 1'b0;
        cyc(1'b1, sv(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0), "fetch");
        cyc(1'b0, ZERO_V, "decode");
        cyc(1'b0, ZERO_V, "exec");
        cyc(1'b0, sv(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), "mem_pre_rst");
        do_reset();
        cyc(1'b1, ZERO_V, "idle_run_low");
        cyc(1'b1, ZERO_V, "idle_run_low2");
        go_fetch();
        cyc(1'b0, sv(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), "fetch_after_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
